cp0_exc_ctrl: RTL and testbench

Exception/interrupt sequencer placed between the decoder and the `cp0` register file. It arbitrates synchronous exceptions (SYSCALL, BREAK, TEQ), ERET and masked external interrupts. It then drives the CP0 write port through a fixed EPC → CAUSE → STATUS write sequence while stalling the core. Finally it redirects the PC to the handler, or back to EPC on ERET.

---
 rtl/cp0_exc_ctrl_if.sv | 37 +++
 rtl/cp0_exc_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : cp0_exc_ctrl_if
// Brief  : Decoder/CP0-side bundle for the exception/interrupt sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface cp0_exc_ctrl_if #(
  parameter int N_INT = 6
);
  logic             instr_valid;
  logic             syscall;
  logic             brk;
  logic             teq_exc;
  logic             eret;
  logic [N_INT-1:0] int_req;
  logic [31:0]      pc;
  logic [31:0]      status;
  logic [31:0]      epc;
  logic             cp0_we;
  logic [4:0]       cp0_waddr;
  logic [31:0]      cp0_wdata;
  logic             stall;
  logic             pc_redirect;
  logic [31:0]      redirect_addr;
  logic [N_INT-1:0] int_ack;

  modport master (
    output instr_valid, syscall, brk, teq_exc, eret, int_req, pc, status, epc,
    input  cp0_we, cp0_waddr, cp0_wdata, stall, pc_redirect, redirect_addr, int_ack
  );

  modport slave (
    input  instr_valid, syscall, brk, teq_exc, eret, int_req, pc, status, epc,
    output cp0_we, cp0_waddr, cp0_wdata, stall, pc_redirect, redirect_addr, int_ack
  );
endinterface
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module : cp0_exc_ctrl
// Brief  : Arbitrates ERET/exceptions/interrupts and sequences EPC, CAUSE,
//          STATUS writes then a PC redirect. CP0_INT_SYNC_EN adds a 2-flop
//          synchronizer on int_req.
// Rev    : 1.0  initial release
// ============================================================================
module cp0_exc_ctrl #(
  parameter int          N_INT        = 6,
  parameter logic [31:0] HANDLER_ADDR = 32'h0040_0004
) (
  input  logic           clk,
  input  logic           reset,
  cp0_exc_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_W_EPC    = 3'd1;
  localparam logic [2:0] S_W_CAUSE  = 3'd2;
  localparam logic [2:0] S_W_STATUS = 3'd3;
  localparam logic [2:0] S_ERET     = 3'd4;
  localparam logic [2:0] S_JUMP     = 3'd5;

  localparam logic [3:0] C_INT = 4'b0000;
  localparam logic [3:0] C_SYS = 4'b1000;
  localparam logic [3:0] C_BRK = 4'b1001;
  localparam logic [3:0] C_TEQ = 4'b1101;

  logic [2:0]       state_q, state_d;
  logic [N_INT-1:0] pend_q, vec_q, ack_q;
  logic [31:0]      pc_q, snap_q, redir_q;
  logic [3:0]       code_q;

  logic [N_INT-1:0] eff;
  logic             ie;
  logic             take_eret, take_exc, take_int, accept;
  logic [3:0]       code;

  logic             cp0_we, stall, pc_redirect;
  logic [4:0]       cp0_waddr;
  logic [31:0]      cp0_wdata;
  logic [N_INT-1:0] int_ack;

`ifdef CP0_INT_SYNC_EN
  logic [N_INT-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pend_q  <= '0;
    end else begin
      sync1_q <= bus.int_req;
      sync2_q <= sync1_q;
      pend_q  <= sync2_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= bus.int_req;
  end
`endif

  assign eff = pend_q & bus.status[8 +: N_INT];
  assign ie  = bus.status[0];

  // Unenabled exceptions drop out of arbitration, letting lower ones through.
  always_comb begin
    take_eret = 1'b0;
    take_exc  = 1'b0;
    take_int  = 1'b0;
    code      = C_INT;
    if (reset && bus.instr_valid && state_q == S_IDLE) begin
      if (bus.eret) begin
        take_eret = 1'b1;
      end else if (bus.syscall && ie && bus.status[1]) begin
        take_exc = 1'b1;
        code     = C_SYS;
      end else if (bus.brk && ie && bus.status[2]) begin
        take_exc = 1'b1;
        code     = C_BRK;
      end else if (bus.teq_exc && ie && bus.status[3]) begin
        take_exc = 1'b1;
        code     = C_TEQ;
      end else if (ie && (|eff)) begin
        take_int = 1'b1;
      end
    end
  end

  assign accept = take_eret | take_exc | take_int;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      snap_q  <= '0;
      code_q  <= '0;
      vec_q   <= '0;
      ack_q   <= '0;
      redir_q <= HANDLER_ADDR;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q    <= bus.pc;
        snap_q  <= bus.status;
        code_q  <= code;
        vec_q   <= eff;
        ack_q   <= take_int ? (eff & (-eff)) : '0;
        redir_q <= take_eret ? bus.epc : HANDLER_ADDR;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take_eret)                 state_d = S_ERET;
        else if (take_exc || take_int) state_d = S_W_EPC;
      end
      S_W_EPC:    state_d = S_W_CAUSE;
      S_W_CAUSE:  state_d = S_W_STATUS;
      S_W_STATUS: state_d = S_JUMP;
      S_ERET:     state_d = S_JUMP;
      S_JUMP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cp0_we      = 1'b0;
    cp0_waddr   = 5'd0;
    cp0_wdata   = 32'd0;
    stall       = 1'b0;
    pc_redirect = 1'b0;
    int_ack     = '0;
    case (state_q)
      S_IDLE: stall = accept;
      S_W_EPC: begin
        cp0_we    = 1'b1;
        cp0_waddr = 5'd14;
        cp0_wdata = pc_q;
        stall     = 1'b1;
        int_ack   = ack_q;
      end
      S_W_CAUSE: begin
        cp0_we               = 1'b1;
        cp0_waddr            = 5'd13;
        cp0_wdata            = 32'(code_q) << 2;
        cp0_wdata[8 +: N_INT] = vec_q;
        stall                = 1'b1;
      end
      S_W_STATUS: begin
        cp0_we    = 1'b1;
        cp0_waddr = 5'd12;
        cp0_wdata = snap_q << 5;
        stall     = 1'b1;
      end
      S_ERET: begin
        cp0_we    = 1'b1;
        cp0_waddr = 5'd12;
        cp0_wdata = snap_q >> 5;
        stall     = 1'b1;
      end
      S_JUMP:  pc_redirect = 1'b1;
      default: ;
    endcase
  end

  assign bus.cp0_we        = cp0_we;
  assign bus.cp0_waddr     = cp0_waddr;
  assign bus.cp0_wdata     = cp0_wdata;
  assign bus.stall         = stall;
  assign bus.pc_redirect   = pc_redirect;
  assign bus.redirect_addr = redir_q;
  assign bus.int_ack       = int_ack;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_cp0_exc_ctrl
// Brief  : Directed vector table plus randomized run against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cp0_exc_ctrl;

  localparam int          NI = 6;
  localparam logic [31:0] H  = 32'h0040_0004;
`ifdef CP0_INT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  cp0_exc_ctrl_if #(.N_INT(NI)) bus ();

  cp0_exc_ctrl #(.N_INT(NI), .HANDLER_ADDR(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit        rstn, iv, sys, brk, teq, eret;
    bit [5:0]  irq;
    bit [31:0] pc, st, epc;
    bit        we;
    bit [4:0]  wa;
    bit [31:0] wd;
    bit        stall, rd, chkra;
    bit [31:0] ra;
    bit [5:0]  ack;
  } vec_t;

  typedef struct {
    bit        we;
    bit [4:0]  wa;
    bit [31:0] wd;
    bit        stall, rd;
    bit [31:0] ra;
    bit [5:0]  ack;
  } exp_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rstn, bit iv, bit sys, bit brk, bit teq, bit eret,
                              bit [5:0] irq, bit [31:0] pc, bit [31:0] st, bit [31:0] epc,
                              bit we, bit [4:0] wa, bit [31:0] wd, bit stall, bit rd,
                              bit chkra, bit [31:0] ra, bit [5:0] ack);
    vec_t v;
    v = '{rstn, iv, sys, brk, teq, eret, irq, pc, st, epc, we, wa, wd, stall, rd, chkra, ra, ack};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input bit rstn, input bit iv, input bit sys, input bit brk,
                       input bit teq, input bit eret, input bit [5:0] irq,
                       input bit [31:0] pc, input bit [31:0] st, input bit [31:0] epc);
    reset           = rstn;
    bus.instr_valid = iv;
    bus.syscall     = sys;
    bus.brk         = brk;
    bus.teq_exc     = teq;
    bus.eret        = eret;
    bus.int_req     = irq;
    bus.pc          = pc;
    bus.status      = st;
    bus.epc         = epc;
  endtask

  task automatic check_outputs(input exp_t e);
    chk("cp0_we",      {31'b0, bus.cp0_we},      {31'b0, e.we});
    chk("cp0_waddr",   {27'b0, bus.cp0_waddr},   {27'b0, e.wa});
    chk("cp0_wdata",   bus.cp0_wdata,            e.wd);
    chk("stall",       {31'b0, bus.stall},       {31'b0, e.stall});
    chk("pc_redirect", {31'b0, bus.pc_redirect}, {31'b0, e.rd});
    chk("int_ack",     {26'b0, bus.int_ack},     {26'b0, e.ack});
  endtask

  // Reference: an accepted request queues the exact per-cycle outputs to come.
  exp_t      q[$];
  bit [5:0]  hist[LAT];

  task automatic model_push(input bit is_eret, input bit is_int, input bit [3:0] code,
                            input bit [5:0] eff, input bit [31:0] pc,
                            input bit [31:0] st, input bit [31:0] epc);
    bit [5:0] ack;
    ack = '0;
    if (is_int) begin
      for (int i = NI - 1; i >= 0; i--) if (eff[i]) ack = 6'(1 << i);
    end
    if (is_eret) begin
      q.push_back('{1, 5'd12, st >> 5, 1, 0, 0, 0});
      q.push_back('{0, 5'd0, 0, 0, 1, epc, 0});
    end else begin
      q.push_back('{1, 5'd14, pc, 1, 0, 0, ack});
      q.push_back('{1, 5'd13, (32'(eff) << 8) + (32'(code) << 2), 1, 0, 0, 0});
      q.push_back('{1, 5'd12, st << 5, 1, 0, 0, 0});
      q.push_back('{0, 5'd0, 0, 0, 1, H, 0});
    end
  endtask

  initial begin
    exp_t e;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    tbl.push_back(mk(0,0,0,0,0,0,6'h00,32'h0,       32'h0,  32'h0,       0,5'd0, 32'h0,       0,0,1,H,0));
    tbl.push_back(mk(1,1,1,0,0,0,6'h00,32'h400100,  32'h3,  32'h0,       0,5'd0, 32'h0,       1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h400100,  32'h3,  32'h0,       1,5'd14,32'h400100,  1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h400100,  32'h3,  32'h0,       1,5'd13,32'h20,      1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h400100,  32'h3,  32'h0,       1,5'd12,32'h60,      1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h400100,  32'h3,  32'h0,       0,5'd0, 32'h0,       0,1,1,H,0));
    tbl.push_back(mk(1,1,0,0,0,1,6'h00,32'h0,       32'h60, 32'h400104,  0,5'd0, 32'h0,       1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'h60, 32'h0,       1,5'd12,32'h3,       1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'h60, 32'h0,       0,5'd0, 32'h0,       0,1,1,32'h400104,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h05,32'h0,       32'h101,32'h0,       0,5'd0, 32'h0,       0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,6'h05,32'h400200,  32'h101,32'h0,       0,5'd0, 32'h0,       1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'h101,32'h0,       1,5'd14,32'h400200,  1,0,0,0,6'h01));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'h101,32'h0,       1,5'd13,32'h100,     1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'h101,32'h0,       1,5'd12,32'h2020,    1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'h101,32'h0,       0,5'd0, 32'h0,       0,1,1,H,0));
    tbl.push_back(mk(1,1,1,0,1,0,6'h00,32'h400300,  32'hF,  32'h0,       0,5'd0, 32'h0,       1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'hF,  32'h0,       1,5'd14,32'h400300,  1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'hF,  32'h0,       1,5'd13,32'h20,      1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'hF,  32'h0,       1,5'd12,32'h1E0,     1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'hF,  32'h0,       0,5'd0, 32'h0,       0,1,1,H,0));
    tbl.push_back(mk(1,1,0,1,0,0,6'h00,32'h400400,  32'h6,  32'h0,       0,5'd0, 32'h0,       0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'h6,  32'h0,       0,5'd0, 32'h0,       0,0,0,0,0));
    tbl.push_back(mk(1,1,1,0,0,0,6'h00,32'h400500,  32'h3,  32'h0,       0,5'd0, 32'h0,       1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'h3,  32'h0,       1,5'd14,32'h400500,  1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,6'h00,32'h0,       32'h3,  32'h0,       1,5'd13,32'h20,      1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'h3,  32'h0,       0,5'd0, 32'h0,       0,0,1,H,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'h3,  32'h0,       0,5'd0, 32'h0,       0,0,0,0,0));
    tbl.push_back(mk(1,1,1,0,0,1,6'h00,32'h400600,  32'h63, 32'h400700,  0,5'd0, 32'h0,       1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'h63, 32'h0,       1,5'd12,32'h3,       1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,6'h00,32'h0,       32'h63, 32'h0,       0,5'd0, 32'h0,       0,1,1,32'h400700,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rstn, tbl[i].iv, tbl[i].sys, tbl[i].brk, tbl[i].teq, tbl[i].eret,
            tbl[i].irq, tbl[i].pc, tbl[i].st, tbl[i].epc);
      #2;
      e = '{tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].stall, tbl[i].rd, tbl[i].ra, tbl[i].ack};
      check_outputs(e);
      if (tbl[i].chkra) chk("redirect_addr", bus.redirect_addr, tbl[i].ra);
    end

    for (int i = 0; i < LAT; i++) hist[i] = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit        rn, iv, sys, brk, teq, eret, acc, is_int;
      bit [5:0]  irq, eff;
      bit [31:0] st, pc, epc;
      bit [3:0]  code;
      @(negedge clk);
      rn   = (cyc == 0) ? 1'b0 : ($urandom_range(63) != 0);
      iv   = ($urandom_range(3) != 0);
      sys  = ($urandom_range(5) == 0);
      brk  = ($urandom_range(5) == 0);
      teq  = ($urandom_range(5) == 0);
      eret = ($urandom_range(7) == 0);
      irq  = bus.int_req;
      if ($urandom_range(7) == 0) irq = 6'($urandom & $urandom);
      st   = $urandom;
      st[0] = st[0] | ($urandom_range(3) != 0);
      pc   = $urandom;
      epc  = $urandom;
      drive(rn, iv, sys, brk, teq, eret, irq, pc, st, epc);
      #2;
      acc = 0; is_int = 0; code = 4'b0000;
      eff = hist[LAT-1] & st[13:8];
      if (q.size() > 0) begin
        e = q[0];
      end else begin
        e = '{default: 0};
        if (rn && iv) begin
          if (eret)                       acc = 1;
          else if (sys && st[0] && st[1]) begin acc = 1; code = 4'b1000; end
          else if (brk && st[0] && st[2]) begin acc = 1; code = 4'b1001; end
          else if (teq && st[0] && st[3]) begin acc = 1; code = 4'b1101; end
          else if (st[0] && eff != 0)     begin acc = 1; is_int = 1; end
        end
        e.stall = acc;
      end
      check_outputs(e);
      if (e.rd) chk("redirect_addr", bus.redirect_addr, e.ra);
      @(posedge clk);
      if (!rn) begin
        q.delete();
        for (int i = 0; i < LAT; i++) hist[i] = '0;
      end else begin
        if (q.size() > 0) void'(q.pop_front());
        else if (acc) model_push(eret, is_int, code, eff, pc, st, epc);
        for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = irq;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
